// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state type and BCD constants for the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int BCD_MAX = 9;
  localparam int BCD_W = 4;
endpackage

// File: rtl/bcd_digit_ctr.sv
// bcd_digit_ctr: single decade counter 0..9 with carry when wrapping from 9
module bcd_digit_ctr
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);
  logic [BCD_W-1:0] r_q;
  assign q = r_q;
  assign carry_out = en && r_q == BCD_W'(BCD_MAX);
  always_ff @(posedge clk)
    if (rst || clr) r_q <= '0;
    else if (en) r_q <= carry_out ? '0 : r_q + 1'b1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear stopwatch with BCD cascade, lap freeze and overflow flag
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_stop,
  input  logic                       clear,
  input  logic                       lap,
  output logic [BCD_W*NDIGITS-1:0]   count_bcd,
  output logic [BCD_W*NDIGITS-1:0]   disp_bcd,
  output logic                       running,
  output logic                       lap_active,
  output logic                       overflow
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t                   r_state;
  logic [PW-1:0]            r_pre;
  logic [BCD_W*NDIGITS-1:0] r_snap;
  logic                     r_lap;
  logic                     r_ovf;
  logic                     w_tick;
  logic [NDIGITS:0]         w_en;
  assign w_tick = r_state == RUN && r_pre == PW'(TICK_DIV - 1);
  assign w_en[0] = w_tick;
  assign running = r_state == RUN;
  assign lap_active = r_lap;
  assign overflow = r_ovf;
  assign disp_bcd = r_lap ? r_snap : count_bcd;
  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    bcd_digit_ctr u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .en        (w_en[i]),
      .q         (count_bcd[BCD_W*i +: BCD_W]),
      .carry_out (w_en[i+1])
    );
  end
  always_ff @(posedge clk)
    if (rst || clear) begin
      r_state <= IDLE;
      r_pre <= '0;
      r_snap <= '0;
      r_lap <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (start_stop) r_state <= r_state == RUN ? PAUSE : RUN;
      if (r_state == RUN) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (lap && r_state == RUN && !r_lap) r_snap <= count_bcd;
      if (lap && r_state != IDLE) r_lap <= r_state == RUN && !r_lap;
      if (w_en[NDIGITS]) r_ovf <= 1'b1;
    end
endmodule
